// File: rtl/led_read_arbiter.sv
// Round-robin arbiter sharing one frame-RAM read port among LED output channels, with host hold/ack.
// Latency: grant in IDLE cycle S, mem_read at S+1, rd_strobe at S+2+READ_LATENCY; requests are level and held until strobed.
module led_read_arbiter #(
  parameter int CHANNELS          = 4,
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int READ_LATENCY      = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CHANNELS-1:0]                   req_valid,
  input  logic [CHANNELS*ADDRESS_BUS_WIDTH-1:0] req_address,
  output logic [15:0]                           rd_data,
  output logic [CHANNELS-1:0]                   rd_strobe,
  output logic [ADDRESS_BUS_WIDTH-1:0]          mem_address,
  output logic                                  mem_read,
  input  logic [15:0]                           mem_data,
  input  logic                                  hold_req,
  output logic                                  hold_ack,
  output logic                                  busy,
  output logic [2:0]                            grant_id
);

  localparam int AW = ADDRESS_BUS_WIDTH;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DELIVER, HOLDOFF} state_t;

  state_t          state, state_n;
  logic [2:0]      ptr;
  logic [3:0]      cnt;
  logic [2:0]      pick;
  logic            pick_vld;
  logic            go;
  logic [AW-1:0]   sel_addr;
  int              off;
  int              best_off;

  // First requesting channel at or after ptr, wrapping; smallest rotated offset wins.
  always_comb begin
    pick     = 3'd0;
    pick_vld = 1'b0;
    off      = 0;
    best_off = CHANNELS;
    sel_addr = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      off = (c + CHANNELS - int'(ptr)) % CHANNELS;
      if (req_valid[c] && off < best_off) begin
        best_off = off;
        pick     = 3'(c);
        pick_vld = 1'b1;
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (3'(c) == pick) sel_addr = req_address[c*AW +: AW];
    end
  end

  always_comb begin
    state_n   = state;
    go        = 1'b0;
    mem_read  = 1'b0;
    busy      = 1'b1;
    rd_strobe = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!hold_req && pick_vld) begin
          go      = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        mem_read = 1'b1;
        state_n  = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_n = DELIVER;
      end
      DELIVER: begin
        rd_strobe = {{(CHANNELS-1){1'b0}}, 1'b1} << grant_id;
        state_n   = HOLDOFF;
      end
      HOLDOFF: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      grant_id    <= 3'd0;
      mem_address <= '0;
      rd_data     <= 16'd0;
      cnt         <= 4'd0;
      hold_ack    <= 1'b0;
    end else begin
      state    <= state_n;
      hold_ack <= (state == IDLE) && hold_req;
      if (go) begin
        grant_id    <= pick;
        mem_address <= sel_addr;
      end
      if (state == ISSUE) cnt <= 4'(READ_LATENCY - 1);
      // Counter reaches zero on the cycle the RAM data is valid.
      if (state == WAIT) begin
        if (cnt == 4'd0) rd_data <= mem_data;
        else             cnt     <= cnt - 4'd1;
      end
      if (state == DELIVER) begin
        ptr <= (grant_id == 3'(CHANNELS - 1)) ? 3'd0 : grant_id + 3'd1;
      end
    end
  end

endmodule
